// File: rtl/prefix_adder_pkg.sv
// Shared types and sizing helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of prefix levels for an operand width.
  function automatic int unsigned nlev(input int unsigned width);
    return $clog2(width);
  endfunction

  // Cycles from accept to out_valid.
  function automatic int unsigned lat(input int unsigned width, input int unsigned reg_every);
    return nlev(width) / reg_every + 1;
  endfunction

endpackage

// File: rtl/gp_merge.sv
// Prefix merge operator: combines a higher (hi) and lower (lo) generate/propagate pair.
module gp_merge
  import prefix_adder_pkg::*;
(
  input  gp_t hi_i,
  input  gp_t lo_i,
  output gp_t gp_o
);

  assign gp_o.g = hi_i.g | (hi_i.p & lo_i.g);
  assign gp_o.p = hi_i.p & lo_i.p;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone adder/subtractor with a register after the g/p stage and after every
// REG_EVERY prefix levels; valid/ready handshake with global stall and synchronous flush.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             grp_g,
  output logic             grp_p
);

  localparam int W    = int'(WIDTH);
  localparam int RE   = int'(REG_EVERY);
  localparam int NL   = int'(nlev(WIDTH));
  localparam int NSTG = NL / RE;

  gp_t  [WIDTH-1:0] gp_d [NSTG+1];
  gp_t  [WIDTH-1:0] gp_q [NSTG+1];
  logic [WIDTH-1:0] pb_q [NSTG+1];
  logic [NSTG:0]    c0_q;
  logic [NSTG:0]    vld_q;
  gp_t  [WIDTH-1:0] gp0;
  logic [WIDTH-1:0] b_eff;
  logic             adv;

  assign adv       = ~(vld_q[NSTG] & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_q[NSTG];
  assign b_eff     = sub ? ~b : b;

  always_comb begin
    gp0 = '0;
    for (int i = 0; i < W; i++) begin
      gp0[i].g = a[i] & b_eff[i];
      gp0[i].p = a[i] ^ b_eff[i];
    end
  end

  assign gp_d[0] = gp0;

  for (genvar s = 1; s <= NSTG; s++) begin : g_stg
    for (genvar j = 0; j < RE; j++) begin : g_lvl
      localparam int Span = 1 << ((s - 1) * RE + j);
      gp_t [WIDTH-1:0] lin;
      gp_t [WIDTH-1:0] lout;
      if (j == 0) begin : g_first
        assign lin = gp_q[s-1];
      end else begin : g_next
        assign lin = g_lvl[j-1].lout;
      end
      for (genvar i = 0; i < W; i++) begin : g_bit
        if (i >= Span) begin : g_mrg
          gp_merge u_merge (
            .hi_i(lin[i]),
            .lo_i(lin[i-Span]),
            .gp_o(lout[i])
          );
        end else begin : g_pass
          assign lout[i] = lin[i];
        end
      end
    end
    assign gp_d[s] = g_lvl[RE-1].lout;
  end

  // Data registers shift only on adv so a stalled result holds; flush clears valids even
  // while stalled, and a simultaneous accept is dropped because vld_q[0] is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c0_q  <= '0;
      for (int s = 0; s <= NSTG; s++) begin
        gp_q[s] <= '0;
        pb_q[s] <= '0;
      end
    end else begin
      if (flush) begin
        vld_q <= '0;
      end else if (adv) begin
        vld_q <= {vld_q[NSTG-1:0], in_valid};
      end
      if (adv) begin
        gp_q[0] <= gp_d[0];
        pb_q[0] <= a ^ b_eff;
        c0_q[0] <= sub | cin;
        for (int s = 1; s <= NSTG; s++) begin
          gp_q[s] <= gp_d[s];
          pb_q[s] <= pb_q[s-1];
          c0_q[s] <= c0_q[s-1];
        end
      end
    end
  end

  // Carry into bit i+1 is the full prefix G[i:0] merged with the carry-in as a pure generate.
  gp_t              cin_gp;
  gp_t  [WIDTH-1:0] cg;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] cp;
  logic             unused_cp;

  assign cin_gp = '{g: c0_q[NSTG], p: 1'b0};

  for (genvar i = 0; i < W; i++) begin : g_carry
    gp_merge u_cmerge (
      .hi_i(gp_q[NSTG][i]),
      .lo_i(cin_gp),
      .gp_o(cg[i])
    );
  end

  always_comb begin
    carry    = '0;
    cp       = '0;
    carry[0] = c0_q[NSTG];
    for (int i = 0; i < W; i++) begin
      carry[i+1] = cg[i].g;
      cp[i]      = cg[i].p;
    end
  end

  assign unused_cp = ^cp;

  assign sum   = pb_q[NSTG] ^ carry[WIDTH-1:0];
  assign cout  = carry[WIDTH];
  assign ovf   = carry[WIDTH] ^ carry[WIDTH-1];
  assign grp_g = gp_q[NSTG][WIDTH-1].g;
  assign grp_p = gp_q[NSTG][WIDTH-1].p;

endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; power of two, 4..64.
REQ-002 SHALL have parameter REG_EVERY, default 2, prefix levels per pipeline stage; must divide NLEV = log2(WIDTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all pipeline valids.
REQ-006 SHALL have port in_valid, input, 1, operands presented.
REQ-007 SHALL have port in_ready, output, 1, operands accepted when in_valid && in_ready.
REQ-008 SHALL have ports a and b, inputs, WIDTH, operands.
REQ-009 SHALL have port cin, input, 1, carry in.
REQ-010 SHALL have port sub, input, 1, subtract mode: computes a - b.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL have port sum, output, WIDTH, result.
REQ-014 SHALL have port cout, output, 1, carry out of the MSB.
REQ-015 SHALL have port ovf, output, 1, two's-complement signed overflow.
REQ-016 SHALL have ports grp_g and grp_p, outputs, 1 each, whole-word group generate/propagate for external chaining.

Function
REQ-017 SHALL form bit-level g = a & b', p = a ^ b', where b' = sub ? ~b : b and carry-in c0 = sub ? 1 : cin.
REQ-018 SHALL combine by Kogge-Stone prefix: level k merges (g,p) at span 2^k; merge (G,P) = (gh | ph & gl, ph & pl).
REQ-019 SHALL register after the g/p stage and after every REG_EVERY prefix levels; latency LAT = NLEV/REG_EVERY + 1 cycles from accept to out_valid (3 at defaults).
REQ-020 SHALL compute sum[i] = p[i] ^ c[i], where c[i] = G[i-1:0] | P[i-1:0] & c0; cout = c[WIDTH]; ovf = c[WIDTH] ^ c[WIDTH-1].
REQ-021 SHALL carry a valid bit per stage; the pipeline advances only when adv = !(out_valid && !out_ready).
REQ-022 SHALL drive in_ready = adv combinationally; in_ready SHALL NOT depend on in_valid.
REQ-023 SHALL hold sum, cout, ovf, grp_g and grp_p stable while out_valid && !out_ready.
REQ-024 SHALL NOT collapse bubbles: an invalid stage advances as a bubble, and full throughput (one result per cycle) is sustained while out_ready = 1.
REQ-025 SHALL, on flush, clear all valid bits at the next edge; flush SHALL win over a simultaneous accept, and that operand SHALL be dropped.
REQ-026 SHALL deliver results in acceptance order with no loss or duplication.

Reset
REQ-027 SHALL, while rst_n = 0, clear all stage valid bits and force out_valid = 0, sum = 0, cout = 0, ovf = 0, grp_g = 0 and grp_p = 0.
REQ-028 SHALL discard in-flight operations when reset is asserted mid-operation; the first result after release SHALL come from the first accept after release.
REQ-029 SHALL drive in_ready = 1 during and immediately after reset.

Structure
REQ-030 SHALL place the gp_t struct {g, p}, the NLEV function and the LAT function in a shared package prefix_adder_pkg.
REQ-031 SHALL implement the merge operator as sub-module gp_merge (inputs hi/lo gp_t, output gp_t), instantiated via generate loops.
REQ-032 SHALL contain no latches; the datapath SHALL be only gp_merge instances and the stage registers.

Verification (WIDTH = 16, REG_EVERY = 2)
REQ-033 SHALL cover: a = 0xFFFF, b = 0x0001, cin = 0, sub = 0 -> 3 cycles later sum = 0x0000, cout = 1, ovf = 0, grp_p = 0, grp_g = 1.
REQ-034 SHALL cover: a = 0x0005, b = 0x0007, sub = 1 -> sum = 0xFFFE, cout = 0, ovf = 0; and a = 0x7FFF, b = 0x0001, sub = 0 -> sum = 0x8000, ovf = 1.
REQ-035 SHALL cover: 6 back-to-back accepts with out_ready = 0 for cycles 3..7 -> in_ready low while stalled, outputs held, all 6 results in order, none lost.
REQ-036 SHALL cover: flush asserted with 3 operations in flight plus a concurrent in_valid -> out_valid = 0 next cycle, no stale results ever emitted.
REQ-037 SHALL cover: rst_n pulsed low asynchronously mid-stream -> out_valid = 0 immediately, and the post-reset result of 0x1234 + 0x1111 = 0x2345 appears 3 cycles after accept.
REQ-038 SHALL cover: 10^5 random a/b/cin/sub operations with random out_ready -> every result matches a reference model of a +/- b + c0.
